// File: rtl/ecc_ram_scrubber_pkg.sv
// Shared definitions for the ECC RAM background scrubber: error-flag bit
// positions, FSM state encoding, counter width and address-width helper.
package ecc_ram_scrubber_pkg;

  localparam int CNT_W         = 16;

  // Bit positions within the decoder's err_b status
  localparam int ERR_NO_ERR    = 0;
  localparam int ERR_CORRECTED = 1;
  localparam int ERR_FATAL     = 2;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_READ     = 3'd2,
    S_WAIT     = 3'd3,
    S_WB_DATA  = 3'd4,
    S_WB_WRITE = 3'd5,
    S_NEXT     = 3'd6,
    S_GAP      = 3'd7
  } state_e;

  // Bits needed to address n words (never less than one bit)
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ecc_ram_scrubber_sat_counter16.sv
// Event counter that sticks at all-ones; a clear beats an increment
// arriving in the same cycle.
module sat_counter16
  import ecc_ram_scrubber_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear dominates, increment holds once saturated
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Count register, cleared by the asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ecc_ram_scrubber.sv
// Background scrubber for the ECC RAM port B. Walks every address, reads it
// through the decoder, writes back corrected data and records fatal words.
// The port is shared with user logic through a req/gnt handshake; losing the
// grant mid-word abandons the word and retries it at the same address.
module ecc_ram_scrubber
  import ecc_ram_scrubber_pkg::*;
#(
  parameter  int NUM_WORDS    = 512,
  parameter  int READ_LATENCY = 3,
  parameter  int SCRUB_GAP    = 1024,
  localparam int ADDR_WIDTH   = addr_width(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear_counts,
  output logic                  port_req,
  input  logic                  port_gnt,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [15:0]           ram_data,
  output logic                  ram_wren,
  input  logic [15:0]           ram_q,
  input  logic [2:0]            ram_err,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  fatal_pulse,
  output logic [ADDR_WIDTH-1:0] fatal_addr,
  output logic [CNT_W-1:0]      corrected_count,
  output logic [CNT_W-1:0]      fatal_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [15:0]           RL_C      = 16'(READ_LATENCY);
  localparam logic [15:0]           GAP_C     = 16'(SCRUB_GAP);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  port_req_q, port_req_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [15:0]           ram_data_q, ram_data_d;
  logic                  ram_wren_q, ram_wren_d;
  logic                  busy_q, busy_d;
  logic                  pass_done_q, pass_done_d;
  logic                  fatal_pulse_q, fatal_pulse_d;
  logic [ADDR_WIDTH-1:0] fatal_addr_q, fatal_addr_d;
  logic                  corr_inc, fatal_inc;

  // Next-state and next-output decode; outputs follow the state being entered
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    fatal_pulse_d = 1'b0;
    fatal_addr_d  = fatal_addr_q;
    corr_inc      = 1'b0;
    fatal_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        if (port_gnt) begin
          state_d       = S_READ;
          ram_address_d = ptr_q;
        end
      end
      S_READ: begin
        if (!port_gnt) begin
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 16'd1;
        end
      end
      S_WAIT: begin
        if (!port_gnt) begin
          state_d = S_REQ;
        end else if (cnt_q == RL_C) begin
          // Decoder status is valid now; fatal outranks corrected
          priority casez (ram_err)
            3'b1??: begin
              state_d       = S_NEXT;
              fatal_pulse_d = 1'b1;
              fatal_addr_d  = ptr_q;
              fatal_inc     = 1'b1;
            end
            3'b01?: begin
              state_d    = S_WB_DATA;
              ram_data_d = ram_q;
            end
            default: state_d = S_NEXT;
          endcase
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WB_DATA: begin
        // Data was presented this cycle; only commit the write while granted
        if (!port_gnt) begin
          state_d = S_REQ;
        end else begin
          state_d       = S_WB_WRITE;
          ram_address_d = ptr_q;
          corr_inc      = 1'b1;
        end
      end
      S_WB_WRITE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;
        if (SCRUB_GAP == 0) begin
          state_d = enable ? S_REQ : S_IDLE;
        end else begin
          state_d = S_GAP;
          cnt_d   = 16'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_C) begin
          state_d = enable ? S_REQ : S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    port_req_d  = (state_d == S_REQ) || (state_d == S_READ) || (state_d == S_WAIT) ||
                  (state_d == S_WB_DATA) || (state_d == S_WB_WRITE);
    ram_wren_d  = (state_d == S_WB_WRITE);
    busy_d      = (state_d != S_IDLE);
    pass_done_d = (state_d == S_NEXT) && (state_q != S_NEXT) && (ptr_q == LAST_ADDR);
  end

  // State, scan pointer and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      port_req_q    <= 1'b0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      pass_done_q   <= 1'b0;
      fatal_pulse_q <= 1'b0;
      fatal_addr_q  <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      port_req_q    <= port_req_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      busy_q        <= busy_d;
      pass_done_q   <= pass_done_d;
      fatal_pulse_q <= fatal_pulse_d;
      fatal_addr_q  <= fatal_addr_d;
    end
  end

  sat_counter16 u_corrected_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_counts),
    .inc   (corr_inc),
    .count (corrected_count)
  );

  sat_counter16 u_fatal_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_counts),
    .inc   (fatal_inc),
    .count (fatal_count)
  );

  assign port_req    = port_req_q;
  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign busy        = busy_q;
  assign pass_done   = pass_done_q;
  assign fatal_pulse = fatal_pulse_q;
  assign fatal_addr  = fatal_addr_q;

endmodule

// File: tb/tb_ecc_ram_scrubber.sv
// Directed bench for ecc_ram_scrubber with an 8-word RAM, no scrub gap and a
// three-stage read pipeline model whose error status is set per address.
module tb_ecc_ram_scrubber;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear_counts;
  logic        port_req;
  logic        port_gnt;
  logic [2:0]  ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic [15:0] ram_q;
  logic [2:0]  ram_err;
  logic        busy;
  logic        pass_done;
  logic        fatal_pulse;
  logic [2:0]  fatal_addr;
  logic [15:0] corrected_count;
  logic [15:0] fatal_count;

  logic        sat_clr;
  logic        sat_inc;
  logic [15:0] sat_count;

  int vec  = 0;
  int miss = 0;

  ecc_ram_scrubber #(
    .NUM_WORDS    (8),
    .READ_LATENCY (3),
    .SCRUB_GAP    (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .clear_counts    (clear_counts),
    .port_req        (port_req),
    .port_gnt        (port_gnt),
    .ram_address     (ram_address),
    .ram_data        (ram_data),
    .ram_wren        (ram_wren),
    .ram_q           (ram_q),
    .ram_err         (ram_err),
    .busy            (busy),
    .pass_done       (pass_done),
    .fatal_pulse     (fatal_pulse),
    .fatal_addr      (fatal_addr),
    .corrected_count (corrected_count),
    .fatal_count     (fatal_count)
  );

  sat_counter16 u_sat (
    .clk   (clk),
    .rst   (rst),
    .clr   (sat_clr),
    .inc   (sat_inc),
    .count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port B model: address register + two decoder stages, data registered
  // one cycle ahead of the write strobe.
  logic [15:0] mem   [8];
  logic [2:0]  emode [8];
  logic [2:0]  a1, a2, a3;
  logic [15:0] din_r;
  int          wr_cnt = 0;
  logic [15:0] wr5_data = 16'h0000;

  always @(posedge clk) begin
    a1    <= ram_address;
    a2    <= a1;
    a3    <= a2;
    din_r <= ram_data;
    if (ram_wren) begin
      wr_cnt <= wr_cnt + 1;
      if (ram_address == 3'd5) wr5_data <= din_r;
    end
  end

  assign ram_err = emode[a3];
  assign ram_q   = emode[a3][2] ? ~mem[a3] : mem[a3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem[i]   = 16'h1000 + 16'(i * 16'h0111);
      emode[i] = 3'b001;
    end
    mem[5]       = 16'hA5A5;
    rst          = 1'b1;
    enable       = 1'b0;
    clear_counts = 1'b0;
    port_gnt     = 1'b1;
    sat_clr      = 1'b0;
    sat_inc      = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_port_req", port_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_addr", ram_address, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_fatal_pulse", fatal_pulse, 0);
    chk("rst_fatal_addr", fatal_addr, 0);
    chk("rst_corr_cnt", corrected_count, 0);
    chk("rst_fatal_cnt", fatal_count, 0);
    #10;
    rst    = 1'b1;
    enable = 1'b1;

    // Clean pass: reads 0..7, pass_done on the last word
    step();
    chk("clean_req", port_req, 1);
    chk("clean_busy", busy, 1);
    for (int w = 0; w < 8; w++) begin
      step();
      chk("clean_read_addr", ram_address, w);
      chk("clean_read_wren", ram_wren, 0);
      repeat (3) step();
      step();
      chk("clean_pass_done", pass_done, (w == 7) ? 1 : 0);
      if (w == 7) enable = 1'b0;
      step();
    end
    chk("clean_idle_busy", busy, 0);
    chk("clean_idle_req", port_req, 0);
    chk("clean_corr_cnt", corrected_count, 0);
    chk("clean_fatal_cnt", fatal_count, 0);
    chk("clean_no_writes", wr_cnt, 0);

    // Every word single-bit corrected: writeback of each word
    for (int i = 0; i < 8; i++) emode[i] = 3'b010;
    enable = 1'b1;
    step();
    for (int w = 0; w < 8; w++) begin
      step();
      chk("corr_read_addr", ram_address, w);
      repeat (3) step();
      step();
      chk("corr_wbdata_data", ram_data, mem[w]);
      chk("corr_wbdata_wren", ram_wren, 0);
      step();
      chk("corr_wbwrite_wren", ram_wren, 1);
      chk("corr_wbwrite_addr", ram_address, w);
      chk("corr_wbwrite_data", ram_data, mem[w]);
      chk("corr_count_step", corrected_count, w + 1);
      if (w == 7) enable = 1'b0;
      step();
      chk("corr_next_wren", ram_wren, 0);
      chk("corr_pass_done", pass_done, (w == 7) ? 1 : 0);
      step();
    end
    chk("corr_count_pass", corrected_count, 8);
    chk("corr_write_count", wr_cnt, 8);
    chk("corr_word5_data", wr5_data, 16'hA5A5);

    // Every word fatal (corrected flag also set): no writeback
    for (int i = 0; i < 8; i++) emode[i] = 3'b110;
    enable = 1'b1;
    step();
    for (int w = 0; w < 8; w++) begin
      step();
      chk("fatal_read_pulse", fatal_pulse, 0);
      repeat (3) step();
      step();
      chk("fatal_pulse", fatal_pulse, 1);
      chk("fatal_addr_word", fatal_addr, w);
      if (w == 7) begin
        chk("fatal_pass_done", pass_done, 1);
        enable = 1'b0;
      end
      step();
    end
    chk("fatal_count_pass", fatal_count, 8);
    chk("fatal_addr_end", fatal_addr, 7);
    chk("fatal_no_writes", wr_cnt, 8);
    chk("fatal_corr_cnt", corrected_count, 8);

    // Grant lost during WB_DATA at address 2: no write, word retried
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    chk("clear_corr_cnt", corrected_count, 0);
    chk("clear_fatal_cnt", fatal_count, 0);
    for (int i = 0; i < 8; i++) emode[i] = 3'b001;
    emode[2] = 3'b010;
    enable   = 1'b1;
    step();
    for (int w = 0; w < 2; w++) begin
      step();
      chk("gnt_read_addr", ram_address, w);
      repeat (4) step();
      step();
    end
    step();
    chk("gnt_read_addr2", ram_address, 2);
    repeat (3) step();
    step();
    chk("gnt_wbdata_data", ram_data, mem[2]);
    port_gnt = 1'b0;
    step();
    chk("gnt_abort_wren", ram_wren, 0);
    chk("gnt_abort_req", port_req, 1);
    chk("gnt_abort_cnt", corrected_count, 0);
    port_gnt = 1'b1;
    step();
    chk("gnt_reread_addr", ram_address, 2);
    chk("gnt_reread_wren", ram_wren, 0);
    repeat (3) step();
    step();
    step();
    chk("gnt_retry_wren", ram_wren, 1);
    chk("gnt_retry_addr", ram_address, 2);
    chk("gnt_retry_cnt", corrected_count, 1);
    enable = 1'b0;
    step();
    step();
    chk("gnt_idle_busy", busy, 0);
    chk("gnt_write_count", wr_cnt, 9);

    // clear_counts in the same cycle as a fatal increment
    for (int i = 0; i < 8; i++) emode[i] = 3'b110;
    enable = 1'b1;
    step();
    step();
    chk("clrwin_read_addr", ram_address, 3);
    repeat (3) step();
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    chk("clrwin_pulse", fatal_pulse, 1);
    chk("clrwin_fatal_cnt", fatal_count, 0);
    chk("clrwin_corr_cnt", corrected_count, 0);
    step();
    step();
    chk("clrwin_read_addr4", ram_address, 4);
    repeat (3) step();
    step();
    chk("clrwin_fatal_cnt_next", fatal_count, 1);
    chk("clrwin_fatal_addr", fatal_addr, 4);
    enable = 1'b0;
    step();

    // Asynchronous reset while the writeback strobe is high
    for (int i = 0; i < 8; i++) emode[i] = 3'b010;
    enable = 1'b1;
    step();
    step();
    chk("arst_read_addr", ram_address, 5);
    repeat (3) step();
    step();
    step();
    chk("arst_wbwrite_wren", ram_wren, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_wren", ram_wren, 0);
    chk("arst_req", port_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", ram_address, 0);
    chk("arst_data", ram_data, 0);
    chk("arst_fatal_addr", fatal_addr, 0);
    chk("arst_fatal_cnt", fatal_count, 0);
    chk("arst_corr_cnt", corrected_count, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("arst_restart_req", port_req, 1);
    step();
    chk("arst_restart_addr", ram_address, 0);
    enable = 1'b0;

    // Saturation of the counter cell
    sat_inc = 1'b1;
    repeat (65534) step();
    chk("sat_fffe", sat_count, 16'hFFFE);
    step();
    chk("sat_ffff", sat_count, 16'hFFFF);
    step();
    chk("sat_hold", sat_count, 16'hFFFF);
    sat_clr = 1'b1;
    step();
    chk("sat_clr_wins", sat_count, 0);
    sat_clr = 1'b0;
    sat_inc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
